// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter that shares a single SPI transfer engine among N_REQ
// requesters. Launches one word per grant, returns the received word (or a
// timeout error) to the owner, then enforces an idle gap before the next launch.
module spi_xfer_arbiter #(
    parameter int unsigned N_REQ          = 2,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      spi_start,
    output logic [DATA_W-1:0]         spi_tx_data,
    input  logic                      spi_busy,
    input  logic                      spi_done,
    input  logic [DATA_W-1:0]         spi_rx_data
);

    localparam int unsigned OwnW = (N_REQ > 2) ? $clog2(N_REQ) : 1;
    localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [OwnW-1:0] PtrRst = OwnW'(N_REQ - 1);
    localparam logic [TmrW-1:0] TmrMax = TmrW'(TIMEOUT_CYCLES);
    localparam logic [GapW-1:0] GapMax = GapW'(GAP_CYCLES);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StGap} state_e;

    state_e              state_q, state_d;
    logic [OwnW-1:0]     ptr_q, ptr_d;
    logic [OwnW-1:0]     owner_q, owner_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic [TmrW-1:0]     timer_q, timer_d;
    logic [GapW-1:0]     gap_q, gap_d;

    logic                found;
    logic [OwnW-1:0]     pick;
    logic [DATA_W-1:0]   pick_data;

    // Round-robin pick: first set request strictly after ptr, then wrap to 0..ptr
    always_comb begin
        found     = 1'b0;
        pick      = '0;
        pick_data = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!found && req[j] && (j > int'(ptr_q))) begin
                found     = 1'b1;
                pick      = OwnW'(j);
                pick_data = req_data[j*DATA_W +: DATA_W];
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!found && req[j] && (j <= int'(ptr_q))) begin
                found     = 1'b1;
                pick      = OwnW'(j);
                pick_data = req_data[j*DATA_W +: DATA_W];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: pointer, owner, latched words, timers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ptr_q      <= PtrRst;
            owner_q    <= '0;
            tx_q       <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            timer_q    <= '0;
            gap_q      <= '0;
        end else begin
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            tx_q       <= tx_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            timer_q    <= timer_d;
            gap_q      <= gap_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        tx_d       = tx_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        timer_d    = timer_q;
        gap_d      = gap_q;
        unique case (state_q)
            StIdle: begin
                if (found && !spi_busy) begin
                    owner_d = pick;
                    tx_d    = pick_data;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                ptr_d   = owner_q;
                timer_d = TmrW'(1);
                state_d = StWait;
            end
            StWait: begin
                // A done pulse on the final timer cycle still counts as success
                if (spi_done) begin
                    rsp_data_d = spi_rx_data;
                    rsp_err_d  = 1'b0;
                    state_d    = StResp;
                end else if (timer_q == TmrMax) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = StResp;
                end else begin
                    timer_d = timer_q + TmrW'(1);
                end
            end
            StResp: begin
                if (GAP_CYCLES == 0) begin
                    state_d = StIdle;
                end else begin
                    gap_d   = GapW'(1);
                    state_d = StGap;
                end
            end
            StGap: begin
                if (gap_q >= GapMax) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state and owner
    always_comb begin
        spi_start   = (state_q == StIssue);
        spi_tx_data = tx_q;
        rsp_data    = rsp_data_q;
        rsp_err     = rsp_err_q;
        gnt         = '0;
        rsp_valid   = '0;
        for (int j = 0; j < N_REQ; j++) begin
            gnt[j]       = (state_q == StIssue) && (int'(owner_q) == j);
            rsp_valid[j] = (state_q == StResp) && (int'(owner_q) == j);
        end
    end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Self-checking bench for spi_xfer_arbiter. The bench plays the SPI engine.
// A second instance with an 8-cycle timeout covers the timeout corner cases.
module tb_spi_xfer_arbiter;

    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [1:0]  req;
    logic [15:0] req_data;
    logic        spi_busy;
    logic        spi_done;
    logic [7:0]  spi_rx_data;

    logic [1:0]  gnt, rsp_valid;
    logic [7:0]  rsp_data, spi_tx_data;
    logic        rsp_err, spi_start;

    logic [1:0]  t_gnt, t_rsp_valid;
    logic [7:0]  t_rsp_data, t_spi_tx_data;
    logic        t_rsp_err, t_spi_start;

    spi_xfer_arbiter #(
        .N_REQ(2), .DATA_W(8), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(32)
    ) u_dut (
        .clk(clk), .rst_b(rst_b), .req(req), .req_data(req_data),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .spi_start(spi_start), .spi_tx_data(spi_tx_data), .spi_busy(spi_busy),
        .spi_done(spi_done), .spi_rx_data(spi_rx_data)
    );

    spi_xfer_arbiter #(
        .N_REQ(2), .DATA_W(8), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(8)
    ) u_dut_to (
        .clk(clk), .rst_b(rst_b), .req(req), .req_data(req_data),
        .gnt(t_gnt), .rsp_valid(t_rsp_valid), .rsp_data(t_rsp_data), .rsp_err(t_rsp_err),
        .spi_start(t_spi_start), .spi_tx_data(t_spi_tx_data), .spi_busy(spi_busy),
        .spi_done(spi_done), .spi_rx_data(spi_rx_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] vld;
        logic [7:0] data;
        logic       err;
    } rsp_t;

    typedef struct {
        logic [1:0] req;
        logic [7:0] d0;
        logic [7:0] d1;
        int         busy;
        int         delay;
        logic [7:0] rx;
        logic [1:0] exp_gnt;
        logic [7:0] exp_tx;
    } vec_t;

    rsp_t exp_q[$];
    vec_t vecs[8];

    int checks = 0;
    int errors = 0;
    int since = 0;
    bit have_rsp = 1'b0;
    bit rsp_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard pop on main-DUT responses, plus launch spacing after each response
    task automatic monitor();
        rsp_t e;
        if (!rst_b) begin
            have_rsp = 1'b0;
            since = 0;
            return;
        end
        if (have_rsp) since++;
        if (spi_start && have_rsp) check("start_spacing", 32'(since >= GAP + 2), 1);
        if (rsp_valid != 2'b00) begin
            rsp_seen = 1'b1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid %0h expected none", rsp_valid);
            end else begin
                e = exp_q.pop_front();
                check("rsp_valid", rsp_valid, e.vld);
                check("rsp_data", rsp_data, e.data);
                check("rsp_err", rsp_err, e.err);
            end
            since = 0;
            have_rsp = 1'b1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
    endtask

    task automatic wait_start(input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            tick();
            if (spi_start) begin
                n = i;
                break;
            end
        end
        if (n < 0) begin
            checks++;
            errors++;
            $display("FAIL start_timeout: got no spi_start expected one within %0d cycles", bound);
        end
    endtask

    // Engine answers `delay` WAIT cycles after launch; main DUT must respond next cycle
    task automatic respond(input int delay, input logic [7:0] rx, input logic [1:0] owner,
                           input logic [7:0] tx);
        rsp_t e;
        e.vld = owner;
        e.data = rx;
        e.err = 1'b0;
        exp_q.push_back(e);
        repeat (delay) tick();
        check("tx_stable", spi_tx_data, tx);
        spi_done = 1'b1;
        spi_rx_data = rx;
        rsp_seen = 1'b0;
        tick();
        spi_done = 1'b0;
        check("rsp_latency", 32'(rsp_seen), 1);
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        req = 2'b00;
        spi_busy = 1'b0;
        spi_done = 1'b0;
        tick();
        tick();
        rst_b = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int n;
        rsp_t e;
        vecs[0] = '{2'b01, 8'hA5, 8'h00, 0, 16, 8'h3C, 2'b01, 8'hA5};
        vecs[1] = '{2'b11, 8'h11, 8'h22, 0, 3, 8'h4D, 2'b10, 8'h22};
        vecs[2] = '{2'b11, 8'h33, 8'h44, 0, 5, 8'h5E, 2'b01, 8'h33};
        vecs[3] = '{2'b10, 8'h00, 8'h55, 5, 4, 8'h6F, 2'b10, 8'h55};
        vecs[4] = '{2'b10, 8'h00, 8'h66, 0, 1, 8'h70, 2'b10, 8'h66};
        vecs[5] = '{2'b11, 8'h77, 8'h88, 0, 2, 8'h81, 2'b01, 8'h77};
        vecs[6] = '{2'b01, 8'h99, 8'h00, 0, 1, 8'h92, 2'b01, 8'h99};
        vecs[7] = '{2'b11, 8'hAA, 8'hBB, 0, 7, 8'hA3, 2'b10, 8'hBB};

        rst_b = 1'b0;
        req = 2'b00;
        req_data = 16'h0000;
        spi_busy = 1'b0;
        spi_done = 1'b0;
        spi_rx_data = 8'h00;
        tick();
        tick();
        check("reset_gnt", gnt, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_spi_start", spi_start, 0);
        check("reset_spi_tx_data", spi_tx_data, 0);
        rst_b = 1'b1;
        tick();

        // Table-driven transfers: RR order, busy hold-off, varying engine latency
        for (int i = 0; i < 8; i++) begin
            req = vecs[i].req;
            req_data = {vecs[i].d1, vecs[i].d0};
            if (vecs[i].busy > 0) begin
                spi_busy = 1'b1;
                for (int k = 0; k < vecs[i].busy; k++) begin
                    tick();
                    check("busy_no_start", spi_start, 0);
                    check("busy_no_gnt", gnt, 0);
                end
                spi_busy = 1'b0;
            end
            wait_start(10, n);
            check("start_latency", n, 1);
            check("gnt", gnt, vecs[i].exp_gnt);
            check("spi_tx_data", spi_tx_data, vecs[i].exp_tx);
            req = 2'b00;
            req_data = 16'hFFFF;
            respond(vecs[i].delay, vecs[i].rx, vecs[i].exp_gnt, vecs[i].exp_tx);
            tick();
            check("rsp_valid_clear", rsp_valid, 0);
            check("rsp_data_hold", rsp_data, vecs[i].rx);
            repeat (2) tick();
        end

        // Both requests held: grants alternate 0,1,0,1
        do_reset();
        req = 2'b11;
        req_data = {8'h22, 8'h11};
        for (int k = 0; k < 4; k++) begin
            wait_start(12, n);
            check("alt_gnt", gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
            check("alt_tx", spi_tx_data, (k % 2 == 0) ? 8'h11 : 8'h22);
            respond(3, 8'h40 + 8'(k), (k % 2 == 0) ? 2'b01 : 2'b10,
                    (k % 2 == 0) ? 8'h11 : 8'h22);
        end
        req = 2'b00;
        repeat (4) tick();

        // Reset while waiting on the engine, then a stray done pulse
        req = 2'b01;
        req_data = {8'h00, 8'hA5};
        wait_start(10, n);
        req = 2'b00;
        repeat (3) tick();
        rst_b = 1'b0;
        #1;
        check("async_rst_gnt", gnt, 0);
        check("async_rst_rsp_valid", rsp_valid, 0);
        check("async_rst_rsp_data", rsp_data, 0);
        check("async_rst_rsp_err", rsp_err, 0);
        check("async_rst_spi_start", spi_start, 0);
        check("async_rst_spi_tx_data", spi_tx_data, 0);
        tick();
        rst_b = 1'b1;
        spi_done = 1'b1;
        spi_rx_data = 8'hEE;
        tick();
        spi_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stray_done_no_start", spi_start, 0);
            check("stray_done_no_rsp", rsp_valid, 0);
        end
        req = 2'b11;
        req_data = {8'hB2, 8'hB1};
        wait_start(10, n);
        check("post_reset_gnt", gnt, 2'b01);
        req = 2'b00;
        respond(2, 8'h5C, 2'b01, 8'hB1);
        repeat (4) tick();

        // Engine never answers: 8-cycle instance times out, main instance at 32
        do_reset();
        req = 2'b01;
        req_data = {8'h00, 8'h5A};
        wait_start(10, n);
        check("to_start", t_spi_start, 1);
        check("to_gnt", t_gnt, 2'b01);
        req = 2'b00;
        e.vld = 2'b01;
        e.data = 8'h00;
        e.err = 1'b1;
        exp_q.push_back(e);
        repeat (8) tick();
        check("to_before_timeout", t_rsp_valid, 0);
        tick();
        check("to_rsp_valid", t_rsp_valid, 2'b01);
        check("to_rsp_err", t_rsp_err, 1);
        check("to_rsp_data", t_rsp_data, 0);
        rsp_seen = 1'b0;
        for (int i = 0; i < 40 && !rsp_seen; i++) tick();
        check("main_timeout_rsp", 32'(rsp_seen), 1);
        req = 2'b10;
        req_data = {8'h77, 8'h00};
        wait_start(10, n);
        check("after_timeout_gnt", gnt, 2'b10);
        req = 2'b00;
        respond(2, 8'h21, 2'b10, 8'h77);
        repeat (4) tick();

        // Done on the exact timeout cycle of the 8-cycle instance
        do_reset();
        req = 2'b01;
        req_data = {8'h00, 8'hC3};
        wait_start(10, n);
        check("coinc_start", t_spi_start, 1);
        req = 2'b00;
        respond(8, 8'hE7, 2'b01, 8'hC3);
        check("coinc_rsp_valid", t_rsp_valid, 2'b01);
        check("coinc_rsp_err", t_rsp_err, 0);
        check("coinc_rsp_data", t_rsp_data, 8'hE7);
        repeat (4) tick();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
